// File: rtl/rvx_pkg.sv
// rvx_pkg: shared RV32 pipeline constants and the IF/ID record
package rvx_pkg;
    localparam logic [31:0] RVX_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RVX_NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard, redirect, imem and observation signals of the fetch stage
interface fetch_stage_if;
    logic        stall_F;
    logic        stall_D;
    logic        flush_D;
    logic        PCSrc_E;
    logic [31:0] PCTarget_E;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PCPlus4_D;
    logic        valid_D;
    logic        misalign_err;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    modport slave (
        input  stall_F, stall_D, flush_D, PCSrc_E, PCTarget_E, imem_rdata,
        output imem_addr, PC_F, Instr_D, PC_D, PCPlus4_D, valid_D, misalign_err,
        output fetch_count, stall_count, flush_count
    );
    modport master (
        output stall_F, stall_D, flush_D, PCSrc_E, PCTarget_E, imem_rdata,
        input  imem_addr, PC_F, Instr_D, PC_D, PCPlus4_D, valid_D, misalign_err,
        input  fetch_count, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_stage_perf_counter.sv
// perf_counter: free-running wrap-around event counter with enable
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q, count_d;
    always_comb count_d = en_i ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk)
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    assign count_o = count_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID pipeline register and fetch/stall/flush counters
module fetch_stage
    import rvx_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RVX_RESET_PC,
    parameter logic [31:0] NOP_INSTR = RVX_NOP_INSTR
) (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.slave bus
);
    logic [31:0] pc_q, pc_d, pc_plus4_f;
    ifid_t       ifid_q, ifid_d, bubble;
    logic        misalign_q, misalign_d;
    assign bubble = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
    // redirect beats stall; flush beats stall
    always_comb begin
        pc_plus4_f = pc_q + 32'd4;
        pc_d       = bus.PCSrc_E ? bus.PCTarget_E : bus.stall_F ? pc_q : pc_plus4_f;
        ifid_d     = bus.flush_D ? bubble : bus.stall_D ? ifid_q :
                     '{instr: bus.imem_rdata, pc: pc_q, pc_plus4: pc_plus4_f, valid: 1'b1};
        misalign_d = misalign_q | (bus.PCSrc_E & (|bus.PCTarget_E[1:0]));
    end
    always_ff @(posedge clk)
        if (reset) begin
            pc_q       <= RESET_PC;
            ifid_q     <= bubble;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ifid_q     <= ifid_d;
            misalign_q <= misalign_d;
        end
    assign bus.imem_addr    = pc_q;
    assign bus.PC_F         = pc_q;
    assign bus.Instr_D      = ifid_q.instr;
    assign bus.PC_D         = ifid_q.pc;
    assign bus.PCPlus4_D    = ifid_q.pc_plus4;
    assign bus.valid_D      = ifid_q.valid;
    assign bus.misalign_err = misalign_q;
    perf_counter u_fetch_cnt (.clk(clk), .rst(reset), .en_i(~bus.flush_D & ~bus.stall_D), .count_o(bus.fetch_count));
    perf_counter u_stall_cnt (.clk(clk), .rst(reset), .en_i(bus.stall_F & ~bus.PCSrc_E), .count_o(bus.stall_count));
    perf_counter u_flush_cnt (.clk(clk), .rst(reset), .en_i(bus.flush_D), .count_o(bus.flush_count));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;
    always #5 clk = ~clk;
    fetch_stage_if bus ();
    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction
    assign bus.imem_rdata = mem(bus.imem_addr);
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_fetch, m_stall, m_flush;
    logic        m_valid, m_mis;
    // reference: what the stage must hold after each edge, from the inputs alone
    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 32'h0; m_instr <= 32'h13; m_pcd <= 32'h0; m_pc4d <= 32'h0; m_valid <= 1'b0;
            m_mis <= 1'b0; m_fetch <= 32'h0; m_stall <= 32'h0; m_flush <= 32'h0;
        end else begin
            m_pc <= bus.PCSrc_E ? bus.PCTarget_E : bus.stall_F ? m_pc : m_pc + 32'd4;
            if (bus.flush_D) begin
                m_instr <= 32'h13; m_pcd <= 32'h0; m_pc4d <= 32'h0; m_valid <= 1'b0;
            end else if (!bus.stall_D) begin
                m_instr <= mem(m_pc); m_pcd <= m_pc; m_pc4d <= m_pc + 32'd4; m_valid <= 1'b1;
            end
            if (bus.PCSrc_E && bus.PCTarget_E[1:0] != 2'b00) m_mis <= 1'b1;
            if (!bus.flush_D && !bus.stall_D) m_fetch <= m_fetch + 32'd1;
            if (bus.stall_F && !bus.PCSrc_E) m_stall <= m_stall + 32'd1;
            if (bus.flush_D) m_flush <= m_flush + 32'd1;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check_model();
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("PC_F", bus.PC_F, m_pc);
        chk("Instr_D", bus.Instr_D, m_instr);
        chk("PC_D", bus.PC_D, m_pcd);
        chk("PCPlus4_D", bus.PCPlus4_D, m_pc4d);
        chk("valid_D", {31'b0, bus.valid_D}, {31'b0, m_valid});
        chk("misalign_err", {31'b0, bus.misalign_err}, {31'b0, m_mis});
        chk("fetch_count", bus.fetch_count, m_fetch);
        chk("stall_count", bus.stall_count, m_stall);
        chk("flush_count", bus.flush_count, m_flush);
    endtask
    task automatic tick();
        @(negedge clk);
        check_model();
    endtask
    task automatic drive(input logic sf, input logic sd, input logic fd, input logic ps, input logic [31:0] tg);
        bus.stall_F = sf; bus.stall_D = sd; bus.flush_D = fd; bus.PCSrc_E = ps; bus.PCTarget_E = tg;
    endtask
    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        tick();
        chk("rst PC_F", bus.PC_F, 32'h0);
        chk("rst Instr_D", bus.Instr_D, 32'h13);
        chk("rst valid_D", {31'b0, bus.valid_D}, 32'h0);
        chk("rst fetch_count", bus.fetch_count, 32'h0);
        reset = 1'b0;
        tick();
        chk("first PC_F", bus.PC_F, 32'h4);
        chk("first Instr_D", bus.Instr_D, 32'h0050_0093);
        chk("first PC_D", bus.PC_D, 32'h0);
        chk("first valid_D", {31'b0, bus.valid_D}, 32'h1);
        chk("first fetch_count", bus.fetch_count, 32'h1);
        tick();
        chk("pre-stall PC_F", bus.PC_F, 32'h8);
        drive(1, 1, 0, 0, 32'h0);
        tick();
        chk("stall PC_F", bus.PC_F, 32'h8);
        chk("stall PC_D", bus.PC_D, 32'h4);
        chk("stall Instr_D", bus.Instr_D, mem(32'h4));
        chk("stall stall_count", bus.stall_count, 32'h1);
        chk("stall fetch_count", bus.fetch_count, 32'h2);
        drive(0, 0, 0, 0, 32'h0);
        tick();
        tick();
        chk("pre-redir PC_F", bus.PC_F, 32'h10);
        drive(0, 0, 1, 1, 32'h40);
        tick();
        chk("redir PC_F", bus.PC_F, 32'h40);
        chk("redir Instr_D", bus.Instr_D, 32'h13);
        chk("redir valid_D", {31'b0, bus.valid_D}, 32'h0);
        chk("redir flush_count", bus.flush_count, 32'h1);
        drive(1, 1, 1, 1, 32'h80);
        tick();
        chk("prio PC_F", bus.PC_F, 32'h80);
        chk("prio Instr_D", bus.Instr_D, 32'h13);
        chk("prio valid_D", {31'b0, bus.valid_D}, 32'h0);
        chk("prio stall_count", bus.stall_count, 32'h1);
        chk("prio flush_count", bus.flush_count, 32'h2);
        drive(0, 0, 0, 1, 32'h42);
        tick();
        chk("mis PC_F", bus.PC_F, 32'h42);
        chk("mis err", {31'b0, bus.misalign_err}, 32'h1);
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("mis sticky", {31'b0, bus.misalign_err}, 32'h1);
        chk("mis PC_F+4", bus.PC_F, 32'h46);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        chk("wrap PC_F top", bus.PC_F, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("wrap PC_F", bus.PC_F, 32'h0);
        chk("wrap PC_D", bus.PC_D, 32'hFFFF_FFFC);
        chk("wrap PCPlus4_D", bus.PCPlus4_D, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            bus.stall_F  = ($urandom_range(0, 3) == 0);
            bus.stall_D  = ($urandom_range(0, 3) == 0);
            bus.flush_D  = ($urandom_range(0, 5) == 0);
            bus.PCSrc_E  = ($urandom_range(0, 7) == 0);
            bus.PCTarget_E = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 7) == 0) bus.PCTarget_E[1:0] = 2'($urandom_range(1, 3));
            tick();
        end
        reset = 1'b0;
        drive(1, 1, 1, 1, 32'h123);
        reset = 1'b1;
        tick();
        chk("rst dominates PC_F", bus.PC_F, 32'h0);
        chk("rst dominates mis", {31'b0, bus.misalign_err}, 32'h0);
        chk("rst dominates flush_count", bus.flush_count, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
